seq_pattern_detector: RTL and testbench

SEQ_PATTERN_DETECTOR -- requirements
Module: seq_pattern_detector

---
 rtl/seq_det_pkg.sv | 18 +
 rtl/seq_pattern_detector_sat_counter.sv | 23 ++
 rtl/seq_pattern_detector.sv | 97 +++++++++
 tb/tb_seq_pattern_detector.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared defaults and width helpers for the serial pattern detector.
package seq_det_pkg;

    localparam logic [7:0] SEQ_DEF_PATTERN = 8'b0000_1011;
    localparam int         SEQ_DEF_LEN     = 4;
    localparam int         SEQ_DEF_OVERLAP = 1;

    // Bits needed to hold the values 0..max_len inclusive.
    function automatic int len_width(input int max_len);
        int w;
        w = 0;
        while ((1 << w) < (max_len + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating up-counter; a clear request outranks an increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // Count up on inc, stick at all-ones, clear wins over inc.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/seq_pattern_detector.sv
// Serial bit-pattern detector with runtime-loadable pattern, length and
// overlap mode, plus a saturating match counter.
module seq_pattern_detector
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 16,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(SEQ_DEF_PATTERN),
    parameter int                 DEF_LEN     = SEQ_DEF_LEN,
    parameter int                 DEF_OVERLAP = SEQ_DEF_OVERLAP,
    localparam int                LEN_W       = len_width(MAX_LEN)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in_bit,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               cfg_err
);

    logic [MAX_LEN-1:0] history;
    logic [LEN_W-1:0]   fill;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;

    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] mask;
    logic               cfg_ok;
    logic               hit;

    // Candidate window, active-length mask and match decision for this cycle.
    // A cfg_load cycle owns the cycle, so its data bit can never produce a hit.
    always_comb begin
        cand = {history[MAX_LEN-2:0], in_bit};
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
        cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
        hit    = in_valid && !cfg_load
                 && (fill >= (len_q - LEN_W'(1)))
                 && (((cand ^ pat_q) & mask) == '0);
    end

    // Configuration, history/fill tracking and registered pulse outputs.
    // Any cfg_load, accepted or rejected, discards the coincident data bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            history <= '0;
            fill    <= '0;
            pat_q   <= DEF_PATTERN;
            len_q   <= LEN_W'(DEF_LEN);
            ovl_q   <= (DEF_OVERLAP != 0);
            match   <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            match   <= hit;
            cfg_err <= cfg_load && !cfg_ok;
            if (cfg_load) begin
                if (cfg_ok) begin
                    pat_q   <= cfg_pattern;
                    len_q   <= cfg_len;
                    ovl_q   <= cfg_overlap;
                    history <= '0;
                    fill    <= '0;
                end
            end else if (in_valid) begin
                history <= cand;
                if (hit) begin
                    if (!ovl_q) begin
                        fill <= '0;
                    end
                end else if (fill < len_q) begin
                    fill <= fill + LEN_W'(1);
                end
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (hit),
        .clr  (cnt_clr),
        .count(match_count)
    );

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector: a default-width instance and a
// 2-bit-counter instance share all inputs.
module tb_seq_pattern_detector;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_bit = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic       cnt_clr = 1'b0;

    logic        match1, cfg_err1;
    logic [15:0] count1;
    logic        match2, cfg_err2;
    logic [1:0]  count2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_pattern_detector dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .match(match1), .match_count(count1), .cfg_err(cfg_err1)
    );

    seq_pattern_detector #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr),
        .match(match2), .match_count(count2), .cfg_err(cfg_err2)
    );

    // One clock of stimulus; outputs are stable #1 after the edge on return.
    task automatic step(input logic v, input logic b, input logic ld, input logic clr);
        @(negedge clk);
        in_valid = v; in_bit = b; cfg_load = ld; cnt_clr = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_vec++; if (match1 !== 1'b0) begin n_err++; $display("FAIL reset_match got %b want 0", match1); end
        n_vec++; if (cfg_err1 !== 1'b0) begin n_err++; $display("FAIL reset_cfg_err got %b want 0", cfg_err1); end
        n_vec++; if (count1 !== 16'd0) begin n_err++; $display("FAIL reset_count1 got %0d want 0", count1); end
        n_vec++; if (count2 !== 2'd0) begin n_err++; $display("FAIL reset_count2 got %0d want 0", count2); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_default();
        logic [6:0] bits;
        logic [6:0] expm;
        bits = 7'b1011011;
        expm = 7'b0001001;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 6; i >= 0; i--) begin
            step(1'b1, bits[i], 1'b0, 1'b0);
            n_vec++;
            if (match1 !== expm[i] || match2 !== expm[i]) begin
                n_err++;
                $display("FAIL default_match bit %0d got %b/%b want %b", 7 - i, match1, match2, expm[i]);
            end
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (match1 !== 1'b0) begin n_err++; $display("FAIL default_pulse_width got %b want 0", match1); end
        n_vec++; if (count1 !== 16'd2) begin n_err++; $display("FAIL default_count got %0d want 2", count1); end
    endtask

    task automatic run_101(input logic ovl, input logic [4:0] expm, input string name);
        logic [4:0] bits;
        bits = 5'b10101;
        cfg_pattern = 8'b0000_0101; cfg_len = 4'd3; cfg_overlap = ovl;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        n_vec++; if (cfg_err1 !== 1'b0) begin n_err++; $display("FAIL %s_load_err got %b want 0", name, cfg_err1); end
        for (int i = 4; i >= 0; i--) begin
            step(1'b1, bits[i], 1'b0, 1'b0);
            n_vec++;
            if (match1 !== expm[i]) begin
                n_err++;
                $display("FAIL %s_match bit %0d got %b want %b", name, 5 - i, match1, expm[i]);
            end
        end
    endtask

    task automatic test_no_overlap();
        run_101(1'b0, 5'b00100, "no_overlap");
        n_vec++; if (count1 !== 16'd3) begin n_err++; $display("FAIL no_overlap_count got %0d want 3", count1); end
    endtask

    task automatic test_overlap();
        run_101(1'b1, 5'b00101, "overlap");
        n_vec++; if (count1 !== 16'd5) begin n_err++; $display("FAIL overlap_count got %0d want 5", count1); end
        n_vec++; if (count2 !== 2'd3) begin n_err++; $display("FAIL overlap_count2_sat got %0d want 3", count2); end
    endtask

    task automatic test_cfg_err();
        logic [3:0] bits;
        logic [3:0] expm;
        bits = 4'b1011;
        expm = 4'b0001;
        do_reset();
        cfg_pattern = 8'b0000_0001; cfg_len = 4'd0; cfg_overlap = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        n_vec++; if (cfg_err1 !== 1'b1) begin n_err++; $display("FAIL cfg_err_len0 got %b want 1", cfg_err1); end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++; if (cfg_err1 !== 1'b0) begin n_err++; $display("FAIL cfg_err_pulse got %b want 0", cfg_err1); end
        cfg_len = 4'd9;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        n_vec++; if (cfg_err2 !== 1'b1) begin n_err++; $display("FAIL cfg_err_len9 got %b want 1", cfg_err2); end
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, bits[i], 1'b0, 1'b0);
            n_vec++;
            if (match1 !== expm[i]) begin
                n_err++;
                $display("FAIL cfg_err_default_match bit %0d got %b want %b", 4 - i, match1, expm[i]);
            end
        end
        n_vec++; if (count1 !== 16'd1) begin n_err++; $display("FAIL cfg_err_count got %0d want 1", count1); end
    endtask

    task automatic test_load_with_data();
        logic [6:0] bits;
        logic [6:0] expm;
        bits = 7'b0111011;
        expm = 7'b0000001;
        cfg_pattern = 8'b0000_1011; cfg_len = 4'd4; cfg_overlap = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        n_vec++; if (match1 !== 1'b0) begin n_err++; $display("FAIL load_data_match got %b want 0", match1); end
        for (int i = 6; i >= 0; i--) begin
            step(1'b1, bits[i], 1'b0, 1'b0);
            n_vec++;
            if (match1 !== expm[i]) begin
                n_err++;
                $display("FAIL load_data_stream bit %0d got %b want %b", 7 - i, match1, expm[i]);
            end
        end
    endtask

    task automatic test_len1();
        logic [4:0] bits;
        logic [4:0] expm;
        bits = 5'b10110;
        expm = 5'b10110;
        cfg_pattern = 8'b0000_0001; cfg_len = 4'd1; cfg_overlap = 1'b0;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 4; i >= 0; i--) begin
            step(1'b1, bits[i], 1'b0, 1'b0);
            n_vec++;
            if (match1 !== expm[i]) begin
                n_err++;
                $display("FAIL len1_match bit %0d got %b want %b", 5 - i, match1, expm[i]);
            end
        end
    endtask

    task automatic test_saturate();
        logic [1:0] exp2 [5];
        exp2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        cfg_pattern = 8'b0000_0001; cfg_len = 4'd1; cfg_overlap = 1'b1;
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            n_vec++;
            if (count2 !== exp2[i] || match2 !== 1'b1) begin
                n_err++;
                $display("FAIL sat_count match %0d got %0d/%b want %0d/1", i + 1, count2, match2, exp2[i]);
            end
        end
        n_vec++; if (count1 !== 16'd5) begin n_err++; $display("FAIL sat_count_wide got %0d want 5", count1); end
        step(1'b1, 1'b1, 1'b0, 1'b1);
        n_vec++; if (match2 !== 1'b1) begin n_err++; $display("FAIL clr_with_match_pulse got %b want 1", match2); end
        n_vec++; if (count2 !== 2'd0 || count1 !== 16'd0) begin n_err++; $display("FAIL clr_with_match_count got %0d/%0d want 0/0", count2, count1); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] bits;
        logic [3:0] expm;
        bits = 4'b1011;
        expm = 4'b0001;
        do_reset();
        for (int i = 3; i >= 0; i--) step(1'b1, bits[i], 1'b0, 1'b0);
        n_vec++; if (count1 !== 16'd1) begin n_err++; $display("FAIL mid_pre_count got %0d want 1", count1); end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #2;
        n_vec++; if (count1 !== 16'd0) begin n_err++; $display("FAIL mid_async_count got %0d want 0", count1); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            step(1'b1, bits[i], 1'b0, 1'b0);
            n_vec++;
            if (match1 !== expm[i]) begin
                n_err++;
                $display("FAIL mid_restart bit %0d got %b want %b", 4 - i, match1, expm[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_no_overlap();
        test_overlap();
        test_cfg_err();
        test_load_with_data();
        test_len1();
        test_saturate();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
